// File: rtl/primo_bcd.sv
// rtl/primo_bcd.sv - sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking is enabled by defining PRIMO_BCD_BLANK_EN.
module primo_bcd #(
  parameter int WIDTH_LOG = 4,
  parameter int DIGITS    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  logic [(1 << WIDTH_LOG)-1:0]   num,
  output logic                          ready,
  output logic                          error,
  output logic [4*DIGITS-1:0]           bcd
);

  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam logic [WIDTH_LOG-1:0] CNT_MAX = WIDTH_LOG'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_ERROR = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       sr_q, sr_d;
  logic [4*DIGITS-1:0]    acc_q, acc_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic [WIDTH_LOG-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [4*DIGITS-1:0]    adj;
  logic [4*DIGITS-1:0]    shifted;
  logic                   ovf_next;

  // Digits above the most significant nonzero one read as 4'hF; digit 0 always shows.
  function automatic logic [4*DIGITS-1:0] blank_digits(input logic [4*DIGITS-1:0] a);
`ifdef PRIMO_BCD_BLANK_EN
    logic seen;
    blank_digits = a;
    seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (a[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen) blank_digits[4*i +: 4] = 4'hF;
    end
`else
    blank_digits = a;
`endif
  endfunction

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
    shifted  = {adj[4*DIGITS-2:0], sr_q[WIDTH-1]};
    ovf_next = ovf_q | adj[4*DIGITS-1];
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_READY, S_ERROR: begin
        if (go) begin
          sr_d    = num;
          acc_d   = '0;
          cnt_d   = CNT_MAX;
          ovf_d   = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = shifted;
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        ovf_d = ovf_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          bcd_d   = blank_digits(shifted);
          state_d = ovf_next ? S_ERROR : S_READY;
        end
      end
      default: begin
`ifdef SIM
        state_d = state_t'('x);
        sr_d    = 'x;
        acc_d   = 'x;
        bcd_d   = 'x;
        cnt_d   = 'x;
        ovf_d   = 'x;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_READY;
      bcd_q   <= blank_digits('0);
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q != S_SHIFT);
  assign error = (state_q == S_ERROR);
  assign bcd   = bcd_q;

endmodule

// File: tb/tb_primo_bcd.sv
// tb/tb_primo_bcd.sv - self-checking bench for primo_bcd, DIGITS=5 and DIGITS=3 instances.
// Expected BCD comes from decimal arithmetic; honours PRIMO_BCD_BLANK_EN when defined.
module tb_primo_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go5 = 1'b0, go3 = 1'b0;
  logic [15:0] num5 = '0, num3 = '0;
  logic        ready5, error5, ready3, error3;
  logic [19:0] bcd5;
  logic [11:0] bcd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  primo_bcd #(.WIDTH_LOG(4), .DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .go(go5), .num(num5),
    .ready(ready5), .error(error5), .bcd(bcd5)
  );

  primo_bcd #(.WIDTH_LOG(4), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .go(go3), .num(num3),
    .ready(ready3), .error(error3), .bcd(bcd3)
  );

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Reference: low `digits` decimal digits of v, packed units-first, optionally blanked.
  function automatic logic [19:0] exp_bcd(input int v, input int digits);
    logic [19:0] r = '0;
    int m = v % pow10(digits);
    int t = m;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef PRIMO_BCD_BLANK_EN
    for (int i = 1; i < digits; i++) begin
      if (m < pow10(i)) r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion on one instance, verify latency, held bcd during SHIFT and the result.
  task automatic convert(input int which, input int v, input string tag);
    int n;
    logic [19:0] prev;
    prev = (which == 5) ? bcd5 : {8'h0, bcd3};
    if (which == 5) begin go5 = 1'b1; num5 = 16'(v); end
    else            begin go3 = 1'b1; num3 = 16'(v); end
    step();
    go5 = 1'b0; go3 = 1'b0;
    num5 = 16'($urandom); num3 = 16'($urandom);
    check({tag, "_busy"}, (which == 5) ? ready5 : ready3, 1'b0);
    check({tag, "_hold"}, (which == 5) ? bcd5 : {8'h0, bcd3}, prev);
    n = 0;
    while (!((which == 5) ? ready5 : ready3) && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, 16);
    check({tag, "_bcd"}, (which == 5) ? bcd5 : {8'h0, bcd3}, exp_bcd(v, which));
    check({tag, "_err"}, (which == 5) ? error5 : error3, 32'(v >= pow10(which)));
  endtask

  logic [19:0] rst_bcd5;
  int          v;
  int          n;

  initial begin
    rst_bcd5 = exp_bcd(0, 5);
`ifndef PRIMO_BCD_BLANK_EN
    rst_bcd5 = '0;
`endif
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_ready", ready5, 1'b1);
    check("rst_error", error5, 1'b0);
    check("rst_bcd", bcd5, rst_bcd5);

    convert(5, 65535, "max");

    // Back-to-back with go held high; num changes after acceptance.
    go5 = 1'b1; num5 = 16'd0;
    step();
    num5 = 16'd1;
    check("b2b0_busy", ready5, 1'b0);
    n = 0;
    while (!ready5 && n < 40) begin step(); n++; end
    check("b2b0_lat", n, 16);
    check("b2b0_bcd", bcd5, exp_bcd(0, 5));
    step();
    go5 = 1'b0;
    check("b2b1_restart", ready5, 1'b0);
    n = 0;
    while (!ready5 && n < 40) begin step(); n++; end
    check("b2b1_lat", n, 16);
    check("b2b1_bcd", bcd5, exp_bcd(1, 5));

    convert(3, 1000, "ovf1000");
    convert(3, 999, "fit999");

    // go and num toggled throughout SHIFT must be ignored.
    go5 = 1'b1; num5 = 16'd4099;
    step();
    n = 0;
    while (!ready5 && n < 40) begin
      go5 = ~go5;
      num5 = 16'($urandom);
      step();
      n++;
    end
    go5 = 1'b0;
    check("ign_lat", n, 16);
    check("ign_bcd", bcd5, exp_bcd(4099, 5));
    for (int i = 0; i < 3; i++) step();
    check("ign_idle", ready5, 1'b1);

    // Reset mid-conversion.
    go5 = 1'b1; num5 = 16'd12345;
    step();
    go5 = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", ready5, 1'b1);
    check("abort_error", error5, 1'b0);
    check("abort_bcd", bcd5, rst_bcd5);
    convert(5, 7, "after_abort");

    convert(5, 0, "zero");
    convert(5, 10007, "v10007");

    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 65535));
      convert(5, v, "rand5");
    end
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 1200)) : int'($urandom_range(0, 65535));
      convert(3, v, "rand3");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
